// File: rtl/game_sequencer_if.sv
// Handshake and status bundle between the jump-game sequencer and its
// datapath, VGA plotter and board keys/displays.
interface game_sequencer_if;
  logic       go;
  logic       grav;
  logic       collide;
  logic       plot_done;
  logic       clear_req;
  logic       erase_req;
  logic       draw_req;
  logic       update_en;
  logic       check_en;
  logic       grav_dir;
  logic       startgame;
  logic       game_over;
  logic       overrun;
  logic [7:0] score;

  modport master (
    input  go, grav, collide, plot_done,
    output clear_req, erase_req, draw_req, update_en, check_en,
           grav_dir, startgame, game_over, overrun, score
  );

  modport slave (
    output go, grav, collide, plot_done,
    input  clear_req, erase_req, draw_req, update_en, check_en,
           grav_dir, startgame, game_over, overrun, score
  );
endinterface

// File: rtl/game_sequencer.sv
// Per-frame sequencer for the jump game: menu/game/over flow, frame pacing,
// gravity-flip capture and plotter arbitration (erase, update, check, draw).
module game_sequencer #(
  parameter int FRAME_DIV = 833333
) (
  input  logic             clk,
  input  logic             resetn,
  game_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    MENU, MENU_WAIT, CLEAR, WAIT_FRAME, ERASE,
    UPDATE, CHECK, COLLIDE, DRAW, OVER
  } state_t;

  localparam logic [19:0] LAST_CNT = 20'(FRAME_DIV - 1);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [19:0] cnt_r;
  logic        frame_pending_r;
  logic        grav_pending_r;
  logic        grav_prev_r;
  logic        grav_dir_r;
  logic        overrun_r;
  logic [7:0]  score_r;
  logic        clear_req_r;
  logic        erase_req_r;
  logic        draw_req_r;
  logic        update_en_r;
  logic        check_en_r;
  logic        startgame_r;
  logic        game_over_r;
  logic        in_game_s;
  logic        tick_s;
  logic        grav_edge_s;
  logic        consume_s;
  logic        flip_s;
  logic        start_s;

  function automatic logic is_game(input state_t s);
    logic g;
    case (s)
      CLEAR, WAIT_FRAME, ERASE, UPDATE, CHECK, COLLIDE, DRAW: g = 1'b1;
      default:                                                g = 1'b0;
    endcase
    return g;
  endfunction

  // Next-state decode; plot_done only advances the state that owns a request.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      MENU:       if (bus.go)        state_nxt_s = MENU_WAIT;  else state_nxt_s = MENU;
      MENU_WAIT:  if (bus.go)        state_nxt_s = MENU_WAIT;  else state_nxt_s = CLEAR;
      CLEAR:      if (bus.plot_done) state_nxt_s = WAIT_FRAME; else state_nxt_s = CLEAR;
      WAIT_FRAME: if (frame_pending_r) state_nxt_s = ERASE;    else state_nxt_s = WAIT_FRAME;
      ERASE:      if (bus.plot_done) state_nxt_s = UPDATE;     else state_nxt_s = ERASE;
      UPDATE:                        state_nxt_s = CHECK;
      CHECK:                         state_nxt_s = COLLIDE;
      COLLIDE:    if (bus.collide)   state_nxt_s = OVER;       else state_nxt_s = DRAW;
      DRAW:       if (bus.plot_done) state_nxt_s = WAIT_FRAME; else state_nxt_s = DRAW;
      OVER:       if (bus.go)        state_nxt_s = MENU_WAIT;  else state_nxt_s = OVER;
      default:                       state_nxt_s = MENU;
    endcase
  end

  // Per-cycle event decode shared by the frame and gravity bookkeeping.
  always_comb begin
    in_game_s   = is_game(state_r);
    tick_s      = in_game_s && (cnt_r == LAST_CNT);
    grav_edge_s = bus.grav & ~grav_prev_r;
    consume_s   = (state_r == WAIT_FRAME) && frame_pending_r;
    flip_s      = (state_r == UPDATE) && grav_pending_r;
    start_s     = (state_nxt_s == CLEAR) && (state_r != CLEAR);
  end

  // FSM state register; requests and strobes are decoded from the next state
  // so each one is a clean register bit aligned with its state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r     <= MENU;
      clear_req_r <= 1'b0;
      erase_req_r <= 1'b0;
      draw_req_r  <= 1'b0;
      update_en_r <= 1'b0;
      check_en_r  <= 1'b0;
      startgame_r <= 1'b0;
      game_over_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      clear_req_r <= (state_nxt_s == CLEAR);
      erase_req_r <= (state_nxt_s == ERASE);
      draw_req_r  <= (state_nxt_s == DRAW);
      update_en_r <= (state_nxt_s == UPDATE);
      check_en_r  <= (state_nxt_s == CHECK);
      startgame_r <= is_game(state_nxt_s);
      game_over_r <= (state_nxt_s == OVER);
    end
  end

  // Frame counter, pending flags, gravity direction and score.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_r           <= 20'd0;
      frame_pending_r <= 1'b0;
      grav_pending_r  <= 1'b0;
      grav_prev_r     <= 1'b0;
      grav_dir_r      <= 1'b0;
      overrun_r       <= 1'b0;
      score_r         <= 8'd0;
    end else if (start_s) begin
      cnt_r           <= 20'd0;
      frame_pending_r <= 1'b0;
      grav_pending_r  <= 1'b0;
      grav_prev_r     <= bus.grav;
      grav_dir_r      <= 1'b0;
      overrun_r       <= 1'b0;
      score_r         <= 8'd0;
    end else begin
      cnt_r           <= (in_game_s && !tick_s) ? cnt_r + 20'd1 : 20'd0;
      // A tick wins over consumption; ticks beyond one pending are dropped.
      frame_pending_r <= tick_s | (frame_pending_r & ~consume_s);
      overrun_r       <= overrun_r | (tick_s & frame_pending_r);
      grav_prev_r     <= bus.grav;
      grav_pending_r  <= (in_game_s & grav_edge_s) | (grav_pending_r & ~flip_s);
      grav_dir_r      <= grav_dir_r ^ flip_s;
      if ((state_r == DRAW) && bus.plot_done && (score_r != 8'd255)) begin
        score_r <= score_r + 8'd1;
      end else begin
        score_r <= score_r;
      end
    end
  end

  assign bus.clear_req = clear_req_r;
  assign bus.erase_req = erase_req_r;
  assign bus.draw_req  = draw_req_r;
  assign bus.update_en = update_en_r;
  assign bus.check_en  = check_en_r;
  assign bus.grav_dir  = grav_dir_r;
  assign bus.startgame = startgame_r;
  assign bus.game_over = game_over_r;
  assign bus.overrun   = overrun_r;
  assign bus.score     = score_r;

endmodule
